// File: rtl/dsi_lane_pkg.sv
// Shared state encoding and line codes for the DSI high-speed lane sequencer.
package dsi_lane_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LP_REQ,
        ST_HS_PREP,
        ST_HS_ZERO,
        ST_SYNC,
        ST_DATA,
        ST_TRAIL,
        ST_EXIT
    } lane_state_t;

    localparam logic [7:0] DSI_SYNC_BYTE = 8'hB8;

    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    // Down-counter preload so that a phase lasts exactly p cycles.
    function automatic logic [7:0] cnt_init(input int p);
        return 8'(p - 1);
    endfunction

endpackage

// File: rtl/dsi_hs_lane_sequencer.sv
// Sequences one DSI data lane through LP request, HS prepare/zero, sync,
// payload, trail and exit, driving the serializer and the LP line drivers.
module dsi_hs_lane_sequencer
    import dsi_lane_pkg::*;
#(
    parameter int P_LPX     = 4,
    parameter int P_PREPARE = 4,
    parameter int P_ZERO    = 10,
    parameter int P_TRAIL   = 6,
    parameter int P_EXIT    = 8
) (
    input  logic       tx_clock_logic,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic [1:0] lp_out,
    output logic       lp_oe,
    output logic       busy,
    output logic       done,
    output logic       underflow
);

    localparam logic [7:0] LPX_INIT   = cnt_init(P_LPX);
    localparam logic [7:0] PREP_INIT  = cnt_init(P_PREPARE);
    localparam logic [7:0] ZERO_INIT  = cnt_init(P_ZERO);
    localparam logic [7:0] TRAIL_INIT = cnt_init(P_TRAIL);
    localparam logic [7:0] EXIT_INIT  = cnt_init(P_EXIT);

    lane_state_t state;
    logic [7:0]  cnt;
    logic        last_b7;

    // Outputs are updated on the same edge as the state they belong to, and
    // the HS and LP drivers always swap on one edge so they never overlap.
    always_ff @(posedge tx_clock_logic) begin
        done      <= 1'b0;
        underflow <= 1'b0;
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= 8'd0;
            last_b7 <= 1'b1;
            lp_out  <= LP11;
            lp_oe   <= 1'b1;
            tx_en   <= 1'b1;
            tx_data <= 8'h00;
            s_ready <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_LP_REQ;
                        cnt    <= LPX_INIT;
                        lp_out <= LP01;
                        busy   <= 1'b1;
                    end
                end
                ST_LP_REQ: begin
                    if (cnt == 8'd0) begin
                        state  <= ST_HS_PREP;
                        cnt    <= PREP_INIT;
                        lp_out <= LP00;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_HS_PREP: begin
                    if (cnt == 8'd0) begin
                        state   <= ST_HS_ZERO;
                        cnt     <= ZERO_INIT;
                        lp_oe   <= 1'b0;
                        tx_en   <= 1'b0;
                        tx_data <= 8'h00;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_HS_ZERO: begin
                    if (cnt == 8'd0) begin
                        state   <= ST_SYNC;
                        tx_data <= DSI_SYNC_BYTE;
                        last_b7 <= DSI_SYNC_BYTE[7];
                        s_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_SYNC, ST_DATA: begin
                    // s_ready low here means the final byte is on tx_data now.
                    if (s_ready && s_valid) begin
                        state   <= ST_DATA;
                        tx_data <= s_data;
                        last_b7 <= s_data[7];
                        if (s_last) s_ready <= 1'b0;
                    end else begin
                        state     <= ST_TRAIL;
                        cnt       <= TRAIL_INIT;
                        s_ready   <= 1'b0;
                        tx_data   <= {8{~last_b7}};
                        underflow <= s_ready;
                    end
                end
                ST_TRAIL: begin
                    if (cnt == 8'd0) begin
                        state   <= ST_EXIT;
                        cnt     <= EXIT_INIT;
                        tx_en   <= 1'b1;
                        lp_oe   <= 1'b1;
                        lp_out  <= LP11;
                        tx_data <= 8'h00;
                        done    <= (P_EXIT == 1);
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_EXIT: begin
                    if (cnt == 8'd0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt  <= cnt - 8'd1;
                        done <= (cnt == 8'd1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsi_hs_lane_sequencer.sv
// Scoreboard bench: the expected per-cycle lane trace is queued from the
// payload description and compared each cycle against the DUT outputs.
module tb_dsi_hs_lane_sequencer;
    import dsi_lane_pkg::*;

    localparam int LPX = 4, PREP = 4, ZERO = 10, TRAIL = 6, EXIT = 8;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic       s_valid = 1'b0, s_last = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready, tx_en, lp_oe, busy, done, underflow;
    logic [7:0] tx_data;
    logic [1:0] lp_out;

    dsi_hs_lane_sequencer dut (
        .tx_clock_logic(clk), .rst(rst), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .tx_data(tx_data), .tx_en(tx_en), .lp_out(lp_out), .lp_oe(lp_oe),
        .busy(busy), .done(done), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] lp;
        logic       oe;
        logic       en;
        logic [7:0] d;
        logic       rdy;
        logic       bsy;
        logic       dn;
        logic       uf;
    } obs_t;

    obs_t       exp_q[$];
    logic [7:0] pay[$];
    int         n_avail = 0, sent = 0;
    logic       hold_start = 1'b0;
    int         checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic obs_t mk(input logic [1:0] lp, input logic oe, input logic en,
                                input logic [7:0] d, input logic rdy, input logic bsy,
                                input logic dn, input logic uf);
        obs_t o;
        o = '{lp: lp, oe: oe, en: en, d: d, rdy: rdy, bsy: bsy, dn: dn, uf: uf};
        return o;
    endfunction

    task automatic push(input obs_t o, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(o);
    endtask

    task automatic push_idle(input int n);
        push(mk(LP11, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), n);
    endtask

    // Expected lane trace for one burst given pay[] and how many bytes are offered.
    task automatic build_burst();
        int         nt;
        logic       uf;
        logic [7:0] last;
        nt   = (n_avail < pay.size()) ? n_avail : pay.size();
        uf   = (n_avail < pay.size());
        last = 8'hB8;
        push(mk(LP01, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), LPX);
        push(mk(LP00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), PREP);
        push(mk(LP00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), ZERO);
        push(mk(LP00, 1'b0, 1'b0, 8'hB8, 1'b1, 1'b1, 1'b0, 1'b0), 1);
        for (int i = 0; i < nt; i++) begin
            push(mk(LP00, 1'b0, 1'b0, pay[i], uf ? 1'b1 : (i != pay.size() - 1),
                    1'b1, 1'b0, 1'b0), 1);
            last = pay[i];
        end
        for (int i = 0; i < TRAIL; i++)
            push(mk(LP00, 1'b0, 1'b0, {8{~last[7]}}, 1'b0, 1'b1, 1'b0, uf && i == 0), 1);
        for (int i = 0; i < EXIT; i++)
            push(mk(LP11, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, i == EXIT - 1, 1'b0), 1);
    endtask

    // One cycle per popped entry; payload is offered for the next edge.
    task automatic run(input int limit);
        int   cyc;
        obs_t o, g;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < limit) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            o = exp_q.pop_front();
            g = {lp_out, lp_oe, tx_en, tx_data, s_ready, busy, done, underflow};
            chk("trace", 32'(g), 32'(o));
            chk("drv_excl", 32'(lp_oe & ~tx_en), 32'd0);
            if (!busy) sent = 0;
            if (sent < n_avail && sent < pay.size()) begin
                s_valid = 1'b1;
                s_data  = pay[sent];
                s_last  = (sent == pay.size() - 1);
                if (s_ready) sent++;
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            cyc++;
        end
    endtask

    task automatic burst(input int avail);
        n_avail = avail;
        sent    = 0;
        @(negedge clk);
        start = 1'b1;
        build_burst();
        push_idle(2);
        run(1000);
    endtask

    initial begin
        push_idle(2);
        run(2);
        rst = 1'b0;
        push_idle(2);
        run(2);

        pay = '{8'h11, 8'h22, 8'hA3};
        burst(3);

        pay = '{8'h01, 8'h7F};
        burst(2);

        pay = '{8'h10, 8'h25, 8'h33, 8'h44, 8'h55};
        burst(2);

        pay = '{8'h5A, 8'h66};
        burst(0);

        // Reset while the second payload byte is on the lane.
        pay = '{8'h81, 8'h92, 8'h13, 8'h24, 8'hC5};
        n_avail = 5;
        sent = 0;
        @(negedge clk);
        start = 1'b1;
        build_burst();
        run(LPX + PREP + ZERO + 3);
        exp_q.delete();
        rst = 1'b1;
        push_idle(1);
        run(1);
        rst = 1'b0;
        push_idle(4);
        run(4);

        // Start held high: back-to-back bursts separated by one IDLE cycle.
        pay = '{8'h3C, 8'hC3};
        n_avail = 2;
        sent = 0;
        @(negedge clk);
        hold_start = 1'b1;
        start = 1'b1;
        build_burst();
        push_idle(1);
        build_burst();
        run(1000);
        hold_start = 1'b0;
        start = 1'b0;
        push_idle(3);
        run(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
